seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the common-anode 7-segment display bank. It holds one BCD nibble per digit and cycles the active digit select. Each nibble passes through the team's BCD-to-segment decoder (0→8'hC0 … 9→8'h90, codes 10–15→8'hFF), adding decimal point and leading-zero blanking. It inserts an all-off blank interval before every digit to suppress ghosting, and applies new values only at frame boundaries so frames never tear.

Parameters:
DIG_NUM, 4, number of digits scanned; range 1–8.
SCAN_DIV, 50000, clock cycles per digit slot; must be at least 2.
BLANK_CYC, 16, cycles at the start of each slot with all outputs off; range 1 to SCAN_DIV-1.

Ports:
clk  in  1  system clock, single clock domain.
rst  in  1  synchronous reset, active-high.
load  in  1  single-cycle strobe that captures data_in and dp_in.
data_in  in  4*DIG_NUM  BCD nibbles; digit k is data_in[4k+3:4k]; digit 0 is least significant.
dp_in  in  DIG_NUM  decimal point enable per digit; 1 means the point is lit.
lz_en  in  1  leading-zero blanking enable; sampled live.
seg_out  out  8  active-low segments; bit 7 is the DP, bits 6:0 are g..a.
dig_sel  out  DIG_NUM  active-low one-hot digit enable.
frame_done  out  1  one-cycle pulse after the last digit slot of each frame.
load_pend  out  1  high while captured data waits for the next frame boundary.

Behaviour:
- The clock and reset are fixed as stated: one clock, clk; rst is synchronous and active-high.
- Reset, applied at any time including mid-slot:
  - slot counter = 0, digit index = 0, state = BLANK.
  - Display and pending registers are cleared to 0; load_pend = 0.
  - Registered outputs on the next edge: seg_out = 8'hFF, dig_sel = all ones, frame_done = 0.
- Slot counter runs 0..SCAN_DIV-1 and wraps to 0.
  - At the wrap the digit index increments, and wraps from DIG_NUM-1 to 0.
- State machine:
  - BLANK while counter < BLANK_CYC.
  - SHOW while counter ≥ BLANK_CYC.
  - BLANK→SHOW occurs when counter reaches BLANK_CYC.
  - SHOW→BLANK occurs at the counter wrap.
- All outputs are registered and lag the counter/state by exactly one cycle.
- In BLANK: seg_out = 8'hFF and dig_sel = all ones.
- In SHOW:
  - dig_sel has bit [index] = 0 and all other bits = 1.
  - seg_out = decode(nibble[index]), with bit 7 cleared if dp[index] = 1.
- Leading-zero blanking, when lz_en = 1:
  - Digit k > 0 is suppressed if its nibble and every higher nibble are 0.
  - A suppressed digit forces seg_out[6:0] = 7'h7F; its DP is still honoured.
  - Digit 0 is never suppressed.
- Frame boundary is the cycle with counter = SCAN_DIV-1 and index = DIG_NUM-1.
  - frame_done pulses high in the cycle after the boundary.
- Load handling:
  - A load captures data_in and dp_in into the pending registers and sets load_pend.
  - At a frame boundary with load_pend = 1, pending is copied to the display registers and load_pend clears.
  - Multiple loads within one frame: the last one wins.
  - Load in the boundary cycle itself: data_in and dp_in go directly to the display registers, and load_pend stays/returns to 0.
- Nibbles 10–15 display blank (8'hFF); the DP still applies.
- DIG_NUM = 1: the index is constant 0 and every slot is a frame boundary.

Test Plan:
Bench parameters: DIG_NUM = 4, SCAN_DIV = 8, BLANK_CYC = 2.
1. Reset, then release with lz_en = 0 → seg_out = FF and dig_sel = F for 2 cycles; then dig_sel = 4'b1110 and seg_out = C0 for 6 cycles; then digit 1 follows the same pattern. frame_done first pulses 32 cycles after release.
2. load 16'h1234 mid-frame → the old display persists and load_pend = 1 until the boundary. The next frame shows digit 0 = 99, digit 1 = B0, digit 2 = A4, digit 3 = F9, with load_pend = 0.
3. lz_en = 1 with data 16'h0070 → digits 3 and 2 show seg_out = FF (their dig_sel is still asserted); digit 1 = F8; digit 0 = C0. With data 16'h0000 → only digit 0 shows C0.
4. dp_in = 4'b0010 with data 16'h0005 and lz_en = 1 → digit 1 = 8'h7F (blanked, DP lit); digit 0 = 92.
5. load 16'h000A in the boundary cycle → applied in the immediately following frame; digit 0 = FF; load_pend is never asserted.
6. Assert rst during a SHOW slot of digit 2 → the next cycle shows seg_out = FF, dig_sel = F, load_pend = 0, and the scan restarts at digit 0 with a blank interval.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
// Blank-then-show per digit slot, leading-zero blanking, frame-aligned updates.
module seg_scan_ctrl #(
    parameter int DIG_NUM   = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [4*DIG_NUM-1:0]   data_in,
    input  logic [DIG_NUM-1:0]     dp_in,
    input  logic                   lz_en,
    output logic [7:0]             seg_out,
    output logic [DIG_NUM-1:0]     dig_sel,
    output logic                   frame_done,
    output logic                   load_pend
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;

    typedef enum logic {BLANK, SHOW} state_t;

    state_t                    state, state_n;
    logic [CW-1:0]             cnt;
    logic [IW-1:0]             idx;
    logic [DIG_NUM-1:0][3:0]   disp, pend;
    logic [DIG_NUM-1:0]        disp_dp, pend_dp;
    logic [DIG_NUM-1:0]        supp;
    logic                      wrap, boundary;
    logic [7:0]                dec;

    function automatic logic [7:0] bcd7(input logic [3:0] n);
        case (n)
            4'd0: bcd7 = 8'hC0;
            4'd1: bcd7 = 8'hF9;
            4'd2: bcd7 = 8'hA4;
            4'd3: bcd7 = 8'hB0;
            4'd4: bcd7 = 8'h99;
            4'd5: bcd7 = 8'h92;
            4'd6: bcd7 = 8'h82;
            4'd7: bcd7 = 8'hF8;
            4'd8: bcd7 = 8'h80;
            4'd9: bcd7 = 8'h90;
            default: bcd7 = 8'hFF;
        endcase
    endfunction

    assign wrap     = (cnt == CW'(SCAN_DIV - 1));
    assign boundary = wrap && (idx == IW'(DIG_NUM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (wrap)
                idx <= (idx == IW'(DIG_NUM - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= BLANK;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            BLANK: if (cnt == CW'(BLANK_CYC - 1)) state_n = SHOW;
            SHOW:  if (wrap)                      state_n = BLANK;
            default: state_n = BLANK;
        endcase
    end

    // A load landing on the boundary itself bypasses the pending stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp      <= '0;
            disp_dp   <= '0;
            pend      <= '0;
            pend_dp   <= '0;
            load_pend <= 1'b0;
        end else if (boundary) begin
            if (load) begin
                disp    <= data_in;
                disp_dp <= dp_in;
            end else if (load_pend) begin
                disp    <= pend;
                disp_dp <= pend_dp;
            end
            load_pend <= 1'b0;
        end else if (load) begin
            pend      <= data_in;
            pend_dp   <= dp_in;
            load_pend <= 1'b1;
        end
    end

    // Walk from the most significant digit down, tracking "all zero so far".
    always_comb begin
        logic z;
        z    = 1'b1;
        supp = '0;
        for (int k = DIG_NUM - 1; k >= 0; k--) begin
            z       = z & (disp[k] == 4'd0);
            supp[k] = lz_en & z & (k != 0);
        end
    end

    assign dec = bcd7(disp[idx]);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_out    <= 8'hFF;
            dig_sel    <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (state == SHOW) begin
                dig_sel <= ~(DIG_NUM'(1) << idx);
                seg_out <= {~disp_dp[idx], supp[idx] ? 7'h7F : dec[6:0]};
            end else begin
                dig_sel <= '1;
                seg_out <= 8'hFF;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: per-frame expectations queued, then
// popped and checked cycle by cycle against the DUT outputs.
module tb_seg_scan_ctrl;
    localparam int DN = 4, SD = 8, BC = 2;

    logic        clk = 1'b0;
    logic        rst, load, lz_en;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic [7:0]  seg_out;
    logic [3:0]  dig_sel;
    logic        frame_done, load_pend;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] dig;
        logic       fd;
        logic       lp;
    } exp_t;

    exp_t q[$];

    seg_scan_ctrl #(.DIG_NUM(DN), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst(rst), .load(load), .data_in(data_in), .dp_in(dp_in),
        .lz_en(lz_en), .seg_out(seg_out), .dig_sel(dig_sel),
        .frame_done(frame_done), .load_pend(load_pend)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_dec(input logic [3:0] n);
        logic [7:0] t [16];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
              8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        return t[n];
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_seg"}, seg_out, 8'hFF);
        chk({tag, "_dig"}, {4'h0, dig_sel}, 8'h0F);
        chk({tag, "_fd"},  {7'h0, frame_done}, 8'h00);
        chk({tag, "_lp"},  {7'h0, load_pend}, 8'h00);
    endtask

    // Expected 32-cycle frame for the given displayed contents.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dp,
                              input logic lz, input int load_at);
        for (int i = 0; i < DN * SD; i++) begin
            exp_t e;
            int   dg, pos;
            logic zero_up;
            dg  = i / SD;
            pos = i % SD;
            zero_up = 1'b1;
            for (int k = dg; k < DN; k++)
                if (d[4*k +: 4] != 4'd0) zero_up = 1'b0;
            if (pos < BC) begin
                e.seg = 8'hFF;
                e.dig = 4'hF;
            end else begin
                e.dig = 4'hF;
                e.dig[dg] = 1'b0;
                e.seg = ref_dec(d[4*dg +: 4]);
                if (lz && dg > 0 && zero_up) e.seg[6:0] = 7'h7F;
                if (dp[dg]) e.seg[7] = 1'b0;
            end
            e.fd = (i == DN * SD - 1);
            e.lp = (load_at >= 0) && (load_at < DN * SD - 2) &&
                   (i > load_at) && (i < DN * SD - 1);
            q.push_back(e);
        end
    endtask

    // Runs one frame; load_at drives a load sampled at the following edge.
    task automatic frame(input string tag, input logic [15:0] d, input logic [3:0] dp,
                         input logic lz, input int load_at,
                         input logic [15:0] ld, input logic [3:0] ldp, input int stop_at);
        lz_en = lz;
        push_frame(d, dp, lz, load_at);
        for (int i = 0; i < DN * SD; i++) begin
            exp_t e;
            cyc();
            if (q.size() == 0) begin
                chk({tag, "_queue_empty"}, 8'h01, 8'h00);
                break;
            end
            e = q.pop_front();
            chk($sformatf("%s_c%0d_seg", tag, i), seg_out, e.seg);
            chk($sformatf("%s_c%0d_dig", tag, i), {4'h0, dig_sel}, {4'h0, e.dig});
            chk($sformatf("%s_c%0d_fd",  tag, i), {7'h0, frame_done}, {7'h0, e.fd});
            chk($sformatf("%s_c%0d_lp",  tag, i), {7'h0, load_pend}, {7'h0, e.lp});
            if (i == stop_at) break;
            if (i == load_at) begin
                load = 1'b1; data_in = ld; dp_in = ldp;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; lz_en = 1'b0; data_in = '0; dp_in = '0;
        cyc();
        cyc();
        chk_reset("reset");
        rst = 1'b0;

        frame("f0_zero",     16'h0000, 4'b0000, 1'b0, -1, 16'h0000, 4'b0000, 99);
        frame("f1_pend",     16'h0000, 4'b0000, 1'b0, 10, 16'h1234, 4'b0000, 99);
        frame("f2_1234",     16'h1234, 4'b0000, 1'b0, 10, 16'h0070, 4'b0000, 99);
        frame("f3_lz0070",   16'h0070, 4'b0000, 1'b1, 10, 16'h0000, 4'b0000, 99);
        frame("f4_lz0000",   16'h0000, 4'b0000, 1'b1, 10, 16'h0005, 4'b0010, 99);
        frame("f5_dp",       16'h0005, 4'b0010, 1'b1, 30, 16'h000A, 4'b0000, 99);
        frame("f6_bndload",  16'h000A, 4'b0000, 1'b0, -1, 16'h0000, 4'b0000, 99);
        // Pending load outstanding, then reset lands in digit 2's show window.
        frame("f7_prerst",   16'h000A, 4'b0000, 1'b0,  5, 16'h9876, 4'b0000, 20);
        q.delete();
        rst = 1'b1;
        cyc();
        chk_reset("midrst");
        rst = 1'b0;
        frame("f8_restart",  16'h0000, 4'b0000, 1'b0, -1, 16'h0000, 4'b0000, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
